// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, default vectors and
// the branch-offset width shared with the control unit and the ALU.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_IRQ_VECTOR = 32'h0000_0100;
  localparam int          BR_OFFSET_W        = 27;

  // Word offset from the instruction, sign-extended and scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [BR_OFFSET_W-1:0] off);
    return {{(32 - BR_OFFSET_W - 2){off[BR_OFFSET_W-1]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit
// (master) and instruction memory (slave).
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, addr, input  rdata, ack);
  modport slave  (input  req, addr, output rdata, ack);
endinterface

// File: rtl/fetch_unit_next_pc_logic.sv
// Combinational next-PC select: iret > ret > taken branch > pc+4, with
// optional interrupt entry overriding the resolved target.
module next_pc_logic
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] IRQ_VECTOR = DEFAULT_IRQ_VECTOR
) (
  input  logic [31:0]            pc,
  input  logic [BR_OFFSET_W-1:0] offset,
  input  logic                   is_beq,
  input  logic                   is_bgt,
  input  logic                   is_ubranch,
  input  logic                   is_ret,
  input  logic                   is_iret,
  input  logic                   flag_eq,
  input  logic                   flag_gt,
  input  logic [31:0]            ret_addr,
  input  logic [31:0]            epc,
  input  logic                   in_isr,
  input  logic                   irq,
  output logic [31:0]            resolved_pc,
  output logic [31:0]            next_pc,
  output logic                   take_irq
);

  logic        taken;
  logic [31:0] target;

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    taken  = is_ubranch | (is_beq & flag_eq) | (is_bgt & flag_gt);
    target = pc + 32'd4;
    if (is_iret)     target = epc;
    else if (is_ret) target = ret_addr;
    else if (taken)  target = pc + branch_offset(offset);

    resolved_pc = {target[31:2], 2'b00};
    // A retiring iret re-opens the interrupt window in the same cycle.
    take_irq    = irq & (~in_isr | is_iret);
    next_pc     = take_irq ? IRQ_VECTOR : resolved_pc;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / next-PC stage with req/ack memory handshake and WAIT
// timeout. Define FETCH_IRQ_EN to enable single-level interrupt entry.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter logic [31:0] IRQ_VECTOR   = DEFAULT_IRQ_VECTOR,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  fetch_unit_if.master        imem,
  output logic                imem_err,
  output logic [31:0]         instr_out,
  output logic                instr_valid,
  output logic [31:0]         pc_out,
  input  logic                retire,
  input  logic                isBeq,
  input  logic                isBgt,
  input  logic                isUbranch,
  input  logic                isRet,
  input  logic                isIret,
  input  logic                flag_eq,
  input  logic                flag_gt,
  input  logic [31:0]         ret_addr,
  input  logic                irq,
  output logic [31:0]         epc_out,
  output logic                in_isr
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

  fetch_state_t state, next_state;
  logic [7:0]   wait_cnt;
  logic         latch_instr, load_pc, cnt_clr, cnt_inc, set_err;
  logic [31:0]  next_pc, resolved_pc;
  logic         take_irq, irq_gated;

  always_comb begin
    next_state  = state;
    imem.req    = 1'b0;
    latch_instr = 1'b0;
    load_pc     = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    set_err     = 1'b0;
    unique case (state)
      ST_FETCH: begin
        imem.req = 1'b1;
        cnt_clr  = 1'b1;
        if (imem.ack) begin
          latch_instr = 1'b1;
          next_state  = ST_EXEC;
        end else begin
          next_state  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        imem.req = 1'b1;
        if (imem.ack) begin
          latch_instr = 1'b1;
          next_state  = ST_EXEC;
        end else if (wait_cnt == WAIT_LAST) begin
          set_err    = 1'b1;
          next_state = ST_HALT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_EXEC: begin
        if (retire) begin
          load_pc    = 1'b1;
          next_state = ST_FETCH;
        end
      end
      ST_HALT: ;
    endcase
    // Request is suppressed for the whole reset cycle, whatever the state.
    if (rst) imem.req = 1'b0;
  end

  assign imem.addr   = pc_out;
  assign instr_valid = (state == ST_EXEC);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      pc_out    <= RESET_PC;
      instr_out <= '0;
      imem_err  <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state <= next_state;
      if (latch_instr) instr_out <= imem.rdata;
      if (load_pc)     pc_out    <= next_pc;
      if (set_err)     imem_err  <= 1'b1;
      if (cnt_clr)      wait_cnt <= '0;
      else if (cnt_inc) wait_cnt <= wait_cnt + 8'd1;
    end
  end

  next_pc_logic #(.IRQ_VECTOR(IRQ_VECTOR)) u_next_pc (
    .pc          (pc_out),
    .offset      (instr_out[BR_OFFSET_W-1:0]),
    .is_beq      (isBeq),
    .is_bgt      (isBgt),
    .is_ubranch  (isUbranch),
    .is_ret      (isRet),
    .is_iret     (isIret),
    .flag_eq     (flag_eq),
    .flag_gt     (flag_gt),
    .ret_addr    (ret_addr),
    .epc         (epc_out),
    .in_isr      (in_isr),
    .irq         (irq_gated),
    .resolved_pc (resolved_pc),
    .next_pc     (next_pc),
    .take_irq    (take_irq)
  );

`ifdef FETCH_IRQ_EN
  assign irq_gated = irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      epc_out <= '0;
      in_isr  <= 1'b0;
    end else if (load_pc) begin
      if (take_irq) begin
        epc_out <= resolved_pc;
        in_isr  <= 1'b1;
      end else if (isIret) begin
        in_isr  <= 1'b0;
      end
    end
  end
`else
  assign irq_gated = 1'b0;
  assign epc_out   = '0;
  assign in_isr    = 1'b0;

  logic unused_irq;
  assign unused_irq = ^{irq, take_irq, resolved_pc, instr_out[31:BR_OFFSET_W]};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of single-instruction vectors plus
// hand-written stall, reset, timeout and interrupt sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_err;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic        retire;
  logic        isBeq, isBgt, isUbranch, isRet, isIret;
  logic        flag_eq, flag_gt;
  logic [31:0] ret_addr;
  logic        irq;
  logic [31:0] epc_out;
  logic        in_isr;

  int checks = 0;
  int errors = 0;

  fetch_unit_if imem ();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem),
    .imem_err    (imem_err),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .retire      (retire),
    .isBeq       (isBeq),
    .isBgt       (isBgt),
    .isUbranch   (isUbranch),
    .isRet       (isRet),
    .isIret      (isIret),
    .flag_eq     (flag_eq),
    .flag_gt     (flag_gt),
    .ret_addr    (ret_addr),
    .irq         (irq),
    .epc_out     (epc_out),
    .in_isr      (in_isr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        beq, bgt, ub, ret, iret, feq, fgt;
    logic [31:0] ret_addr;
    logic [31:0] pc;
    logic [31:0] next;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic [31:0] rdata,
                              input logic beq, input logic bgt, input logic ub,
                              input logic ret, input logic iret,
                              input logic feq, input logic fgt,
                              input logic [31:0] ra, input logic [31:0] pc,
                              input logic [31:0] next);
    vec_t v;
    v.rdata = rdata; v.beq = beq; v.bgt = bgt; v.ub = ub; v.ret = ret;
    v.iret = iret; v.feq = feq; v.fgt = fgt; v.ret_addr = ra;
    v.pc = pc; v.next = next;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    retire = 1'b0; isBeq = 1'b0; isBgt = 1'b0; isUbranch = 1'b0;
    isRet = 1'b0; isIret = 1'b0; flag_eq = 1'b0; flag_gt = 1'b0;
    ret_addr = '0; irq = 1'b0;
  endtask

  // Fetch with immediate ack, retire immediately, check the following fetch.
  task automatic run_vec(input vec_t v, input logic irq_in);
    check("fetch_req", 32'(imem.req), 32'd1);
    check("fetch_addr", imem.addr, v.pc);
    imem.ack = 1'b1; imem.rdata = v.rdata;
    step();
    imem.ack = 1'b0; imem.rdata = '0;
    check("exec_valid", 32'(instr_valid), 32'd1);
    check("exec_req", 32'(imem.req), 32'd0);
    check("exec_instr", instr_out, v.rdata);
    check("exec_pc", pc_out, v.pc);
    retire = 1'b1; isBeq = v.beq; isBgt = v.bgt; isUbranch = v.ub;
    isRet = v.ret; isIret = v.iret; flag_eq = v.feq; flag_gt = v.fgt;
    ret_addr = v.ret_addr; irq = irq_in;
    step();
    clear_ctrl();
    check("next_addr", imem.addr, v.next);
    check("refetch_valid", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    //               rdata          beq bgt ub ret iret feq fgt ret_addr       pc             next
    vecs[0]  = mk(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0000, 32'h0000_0004);
    vecs[1]  = mk(32'h1111_1111, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0004, 32'h0000_0008);
    vecs[2]  = mk(32'h2222_2222, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0008, 32'h0000_000C);
    vecs[3]  = mk(32'h3333_3333, 0, 0, 0, 0, 0, 1, 1, 32'h0,         32'h0000_000C, 32'h0000_0010);
    vecs[4]  = mk(32'h07FF_FFFE, 1, 0, 0, 0, 0, 1, 0, 32'h0,         32'h0000_0010, 32'h0000_0008);
    vecs[5]  = mk(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0008, 32'h0000_000C);
    vecs[6]  = mk(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0000_000C, 32'h0000_0010);
    vecs[7]  = mk(32'h07FF_FFFE, 1, 0, 0, 0, 0, 0, 1, 32'h0,         32'h0000_0010, 32'h0000_0014);
    vecs[8]  = mk(32'h0000_0004, 0, 1, 0, 0, 0, 1, 1, 32'h0,         32'h0000_0014, 32'h0000_0024);
    vecs[9]  = mk(32'h0000_0004, 0, 1, 0, 0, 0, 1, 0, 32'h0,         32'h0000_0024, 32'h0000_0028);
    vecs[10] = mk(32'h0000_0000, 0, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0000_0028, 32'h0000_0028);
    vecs[11] = mk(32'h0000_0040, 0, 0, 1, 1, 0, 0, 0, 32'h0000_0203, 32'h0000_0028, 32'h0000_0200);
    vecs[12] = mk(32'hF800_0010, 0, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0000_0200, 32'h0000_0240);
    vecs[13] = mk(32'h0000_0000, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFE, 32'h0000_0240, 32'hFFFF_FFFC);
    vecs[14] = mk(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000);
    vecs[15] = mk(32'h0000_0000, 0, 0, 0, 1, 1, 0, 0, 32'h0000_0055, 32'h0000_0000, 32'h0000_0000);
    vecs[16] = mk(32'h0400_0000, 1, 0, 0, 0, 0, 1, 1, 32'h0,         32'h0000_0000, 32'hF000_0000);
    vecs[17] = mk(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'hF000_0000, 32'hF000_0004);

    clear_ctrl();
    imem.ack = 1'b0; imem.rdata = '0;
    rst = 1'b1;
    step();
    step();
    check("rst_req", 32'(imem.req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr_out, 32'd0);
    check("rst_pc", pc_out, 32'h0000_0000);
    check("rst_err", 32'(imem_err), 32'd0);
    check("rst_epc", epc_out, 32'd0);
    check("rst_in_isr", 32'(in_isr), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req", 32'(imem.req), 32'd1);

    for (int i = 0; i < 18; i++) run_vec(vecs[i], 1'b0);

    // Stall: ack withheld for 5 cycles; a stray retire must be ignored.
    retire = 1'b1; isUbranch = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_req", 32'(imem.req), 32'd1);
      check("stall_addr", imem.addr, 32'hF000_0004);
      check("stall_valid", 32'(instr_valid), 32'd0);
      step();
    end
    clear_ctrl();
    imem.ack = 1'b1; imem.rdata = 32'hABCD_0001;
    step();
    check("stall_exec_instr", instr_out, 32'hABCD_0001);
    imem.rdata = 32'hDEAD_BEEF;
    step();
    imem.ack = 1'b0; imem.rdata = '0;
    check("exec_ack_ignored", instr_out, 32'hABCD_0001);
    check("exec_hold_valid", 32'(instr_valid), 32'd1);
    check("exec_hold_pc", pc_out, 32'hF000_0004);
    retire = 1'b1;
    step();
    clear_ctrl();
    check("stall_next_addr", imem.addr, 32'hF000_0008);

    // Reset while an instruction is executing.
    imem.ack = 1'b1; imem.rdata = 32'h1234_5678;
    step();
    imem.ack = 1'b0;
    check("mid_exec_valid", 32'(instr_valid), 32'd1);
    rst = 1'b1;
    step();
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_pc", pc_out, 32'h0000_0000);
    check("mid_rst_instr", instr_out, 32'd0);
    check("mid_rst_req", 32'(imem.req), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("mid_rst_refetch_req", 32'(imem.req), 32'd1);
    check("mid_rst_refetch_addr", imem.addr, 32'h0000_0000);

    // Timeout: one FETCH cycle then 255 WAIT cycles, then HALT.
    for (int i = 0; i < 255; i++) step();
    check("wait_last_req", 32'(imem.req), 32'd1);
    check("wait_last_err", 32'(imem_err), 32'd0);
    step();
    check("halt_req", 32'(imem.req), 32'd0);
    check("halt_err", 32'(imem_err), 32'd1);
    imem.ack = 1'b1; retire = 1'b1;
    for (int i = 0; i < 3; i++) step();
    imem.ack = 1'b0; retire = 1'b0;
    check("halt_stuck_req", 32'(imem.req), 32'd0);
    check("halt_sticky_err", 32'(imem_err), 32'd1);
    check("halt_valid", 32'(instr_valid), 32'd0);
    rst = 1'b1;
    step();
    check("halt_rst_err", 32'(imem_err), 32'd0);
    check("halt_rst_pc", pc_out, 32'h0000_0000);
    rst = 1'b0;
    #1;
    check("halt_rst_req", 32'(imem.req), 32'd1);

`ifdef FETCH_IRQ_EN
    run_vec(mk(32'h0000_0010, 0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0000_0000, 32'h0000_0040), 1'b0);
    run_vec(mk(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0040, 32'h0000_0100), 1'b1);
    check("irq_epc", epc_out, 32'h0000_0044);
    check("irq_in_isr", 32'(in_isr), 32'd1);
    run_vec(mk(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0100, 32'h0000_0104), 1'b1);
    check("irq_masked_epc", epc_out, 32'h0000_0044);
    check("irq_masked_in_isr", 32'(in_isr), 32'd1);
    run_vec(mk(32'h0000_0000, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0000_0104, 32'h0000_0044), 1'b0);
    check("iret_in_isr", 32'(in_isr), 32'd0);
`else
    run_vec(mk(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0000, 32'h0000_0004), 1'b1);
    check("no_irq_epc", epc_out, 32'd0);
    check("no_irq_in_isr", 32'(in_isr), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
